// File: rtl/piso_pkg.sv
// piso_pkg: shared constants for the parallel-in serial-out shift register.
//   PISO_DEFAULT_WIDTH - default parallel word width
//   PISO_DEFAULT_FILL  - default bit shifted into the vacated register end
package piso_pkg;

    localparam int   PISO_DEFAULT_WIDTH = 4;
    localparam logic PISO_DEFAULT_FILL  = 1'b0;

endpackage : piso_pkg

// File: rtl/piso.sv
// piso: parallel-in, serial-out shift register.
// Captures a WIDTH-bit word when load is high and then emits it one bit
// per clock. The first bit appears right after the load edge.
// Ports:
//   clk     - rising-edge clock for all state
//   reset   - asynchronous, active-high clear of the shift register
//   load    - 1: capture datain at the next edge, 0: shift at the next edge
//   datain  - parallel word, sampled only on edges where load=1
//   dataout - serial bit, the output-end bit of the shift register
module piso
    import piso_pkg::*;
#(
    parameter int   WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic FILL_BIT  = PISO_DEFAULT_FILL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] datain,
    output logic             dataout
);

    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shift_s;

    // Shift direction and output end are fixed at elaboration time.
    // dataout is taken straight from a register bit, so no input reaches it
    // combinationally.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_s = {shreg_r[WIDTH-2:0], FILL_BIT};
            assign dataout = shreg_r[WIDTH-1];
        end else begin : g_lsb_first
            assign shift_s = {FILL_BIT, shreg_r[WIDTH-1:1]};
            assign dataout = shreg_r[0];
        end
    endgenerate

    // Shift register: reset clears, load captures the word, otherwise shift.
    // The fill bit enters the vacated end, so over-shifting never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r <= {WIDTH{1'b0}};
        end else if (load) begin
            shreg_r <= datain;
        end else begin
            shreg_r <= shift_s;
        end
    end

endmodule : piso

// File: tb/tb_piso.sv
// tb_piso: self-checking bench for piso. Three instances cover
// WIDTH=4 MSB-first fill 0, WIDTH=8 LSB-first fill 0 and fill 1.
// Expected serial bits are queued as each stimulus step is driven and
// popped and compared one time unit after the clock edge that produces them.
module tb_piso;

    logic       clk;
    logic       reset;

    logic       load4;
    logic [3:0] din4;
    logic       dout4;

    logic       load8;
    logic [7:0] din8;
    logic       dout8;
    logic       dout8f;

    int checks;
    int failures;

    logic exp4_q[$];
    logic exp8_q[$];
    logic exp8f_q[$];

    piso #(.WIDTH(4), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) u_w4 (
        .clk(clk), .reset(reset), .load(load4), .datain(din4), .dataout(dout4)
    );

    piso #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL_BIT(1'b0)) u_w8 (
        .clk(clk), .reset(reset), .load(load8), .datain(din8), .dataout(dout8)
    );

    piso #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL_BIT(1'b1)) u_w8f (
        .clk(clk), .reset(reset), .load(load8), .datain(din8), .dataout(dout8f)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One edge on the WIDTH=4 instance; inputs are driven 1 after an edge.
    task automatic step4(input string tag, input logic ld, input logic [3:0] d,
                         input logic e);
        load4 = ld;
        din4  = d;
        exp4_q.push_back(e);
        @(posedge clk);
        #1;
        chk(tag, dout4, exp4_q.pop_front());
    endtask

    // One edge on both WIDTH=8 instances (fill 0 and fill 1 expectations).
    task automatic step8(input string tag, input logic ld, input logic [7:0] d,
                         input logic e0, input logic e1);
        load8 = ld;
        din8  = d;
        exp8_q.push_back(e0);
        exp8f_q.push_back(e1);
        @(posedge clk);
        #1;
        chk({tag, "_f0"}, dout8, exp8_q.pop_front());
        chk({tag, "_f1"}, dout8f, exp8f_q.pop_front());
    endtask

    logic [7:0] a5_bits;

    initial begin
        checks   = 0;
        failures = 0;
        load8    = 1'b0;
        din8     = 8'h00;

        // 1. Reset while loading zeros: output low immediately.
        reset = 1'b1;
        load4 = 1'b1;
        din4  = 4'b0000;
        #1;
        chk("rst_w4_imm", dout4, 1'b0);
        chk("rst_w8_imm", dout8, 1'b0);
        chk("rst_w8f_imm", dout8f, 1'b0);
        @(posedge clk);
        #1;
        // Reset wins over load even with a nonzero word on the bus.
        step4("rst_prio", 1'b1, 4'b1111, 1'b0);
        reset = 1'b0;
        step4("rel_load0", 1'b1, 4'b0000, 1'b0);

        // 2. Load 1010 then shift with datain=0101 (ignored).
        step4("w4_load", 1'b1, 4'b1010, 1'b1);
        step4("w4_sh1", 1'b0, 4'b0101, 1'b0);
        step4("w4_sh2", 1'b0, 4'b0101, 1'b1);
        step4("w4_sh3", 1'b0, 4'b0101, 1'b0);

        // 3. Over-shift: fill bit, no wrap-around.
        step4("w4_over1", 1'b0, 4'b1111, 1'b0);
        step4("w4_over2", 1'b0, 4'b1111, 1'b0);

        // 4. Mid-word reload.
        step4("mid_load1", 1'b1, 4'b1010, 1'b1);
        step4("mid_sh", 1'b0, 4'b0000, 1'b0);
        step4("mid_load2", 1'b1, 4'b0011, 1'b0);
        step4("mid_sh1", 1'b0, 4'b1010, 1'b0);
        step4("mid_sh2", 1'b0, 4'b1010, 1'b1);
        step4("mid_sh3", 1'b0, 4'b1010, 1'b1);

        // Back-to-back loads follow each new word's MSB.
        step4("b2b_1", 1'b1, 4'b1000, 1'b1);
        step4("b2b_2", 1'b1, 4'b0111, 1'b0);
        step4("b2b_3", 1'b1, 4'b1001, 1'b1);

        // 5. Asynchronous reset mid-cycle while shifting 1111.
        step4("ar_load", 1'b1, 4'b1111, 1'b1);
        step4("ar_sh", 1'b0, 4'b0000, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_drop", dout4, 1'b0);
        #2;
        reset = 1'b0;
        step4("ar_reload", 1'b1, 4'b1001, 1'b1);
        step4("ar_sh1", 1'b0, 4'b0000, 1'b0);
        step4("ar_sh2", 1'b0, 4'b0000, 1'b0);
        step4("ar_sh3", 1'b0, 4'b0000, 1'b1);
        load4 = 1'b0;

        // 6. WIDTH=8, LSB first: A5 -> 1,0,1,0,0,1,0,1 then the fill bit.
        a5_bits = 8'hA5;
        step8("w8_load", 1'b1, a5_bits, a5_bits[0], a5_bits[0]);
        for (int i = 1; i < 8; i++) begin
            step8($sformatf("w8_sh%0d", i), 1'b0, 8'hFF, a5_bits[i], a5_bits[i]);
        end
        step8("w8_fill1", 1'b0, 8'h00, 1'b0, 1'b1);
        step8("w8_fill2", 1'b0, 8'h00, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piso
